lista_aberta: RTL and testbench

Parametrised open-list engine for the path-search datapath. It holds up to NUM_NA active nodes, each with an address, distance, predecessor and criterion. It supports insert with decrease-key, pop-minimum and clear through a valid/ready command port. A sequential scanner keeps the current minimum-criterion node cached, with a selectable tie-break mode. It extends the active-node evaluator toward a self-contained priority set that the search controller drives directly.

---
 rtl/lista_aberta.sv | 206 ++++++++++++++++++++
 tb/tb_lista_aberta.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lista_aberta.sv
// Open-list engine: up to NUM_NA active nodes with insert/decrease-key, pop-minimum and clear.
// A slot-by-slot scanner refreshes the cached minimum after every state-changing command.
module lista_aberta_slot #(
  parameter int ADR_WIDTH       = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CRITERIO_WIDTH  = 6
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       upd,
  input  logic [ADR_WIDTH-1:0]       novo_endereco,
  input  logic [DISTANCIA_WIDTH-1:0] novo_distancia,
  input  logic [ADR_WIDTH-1:0]       novo_anterior,
  input  logic [CRITERIO_WIDTH-1:0]  novo_criterio,
  output logic                       ativo,
  output logic [ADR_WIDTH-1:0]       endereco,
  output logic [DISTANCIA_WIDTH-1:0] distancia,
  output logic [ADR_WIDTH-1:0]       anterior,
  output logic [CRITERIO_WIDTH-1:0]  criterio
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ativo     <= 1'b0;
      endereco  <= '0;
      distancia <= '0;
      anterior  <= '0;
      criterio  <= '0;
    end else if (clr) begin
      ativo <= 1'b0;
    end else if (load) begin
      ativo     <= 1'b1;
      endereco  <= novo_endereco;
      distancia <= novo_distancia;
      anterior  <= novo_anterior;
      criterio  <= novo_criterio;
    end else if (upd) begin
      distancia <= novo_distancia;
      anterior  <= novo_anterior;
      criterio  <= novo_criterio;
    end
  end
endmodule

module lista_aberta #(
  parameter int NUM_NA          = 8,
  parameter int ADR_WIDTH       = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int CRITERIO_WIDTH  = 6,
  parameter int DESEMPATE       = 0
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid_in,
  input  logic [1:0]                     cmd_op_in,
  output logic                           cmd_ready_out,
  input  logic [ADR_WIDTH-1:0]           endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0]     distancia_in,
  input  logic [CUSTO_WIDTH-1:0]         heuristica_in,
  input  logic [ADR_WIDTH-1:0]           anterior_in,
  output logic                           res_valid_out,
  output logic [ADR_WIDTH-1:0]           res_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]     res_distancia_out,
  output logic [ADR_WIDTH-1:0]           res_anterior_out,
  output logic                           menor_valido_out,
  output logic [ADR_WIDTH-1:0]           menor_endereco_out,
  output logic [CRITERIO_WIDTH-1:0]      menor_criterio_out,
  output logic [$clog2(NUM_NA+1)-1:0]    ocupacao_out,
  output logic                           vazio_out,
  output logic                           cheio_out,
  output logic                           estouro_out
);
  localparam int OW = $clog2(NUM_NA+1);
  localparam int SW = $clog2(NUM_NA);

  typedef enum logic {PRONTO, BUSCA} estado_t;
  estado_t estado;

  logic [NUM_NA-1:0]                      ativo, casa, livre, upd, load, clr;
  logic [NUM_NA-1:0][ADR_WIDTH-1:0]       endereco, anterior;
  logic [NUM_NA-1:0][DISTANCIA_WIDTH-1:0] distancia;
  logic [NUM_NA-1:0][CRITERIO_WIDTH-1:0]  criterio;
  logic [CRITERIO_WIDTH-1:0]              novo_criterio;
  logic [OW-1:0]                          ocup;
  logic                                   aceito, op_ins, op_pop, op_clr, vai_busca, acerto, achou;

  logic [SW-1:0]                          cnt, best_idx, nxt_idx, menor_idx;
  logic                                   best_vld, nxt_vld, troca;
  logic [CRITERIO_WIDTH-1:0]              best_crit, nxt_crit;
  logic [DISTANCIA_WIDTH-1:0]             best_dist, nxt_dist;

  assign novo_criterio = CRITERIO_WIDTH'(distancia_in) + CRITERIO_WIDTH'(heuristica_in);
  assign aceito    = cmd_valid_in & cmd_ready_out;
  assign op_ins    = aceito & (cmd_op_in == 2'b01);
  assign op_pop    = aceito & (cmd_op_in == 2'b10) & ~vazio_out;
  assign op_clr    = aceito & (cmd_op_in == 2'b11);
  assign vai_busca = op_ins | op_pop | op_clr;

  always_comb begin
    ocup  = '0;
    livre = '0;
    achou = 1'b0;
    for (int i = 0; i < NUM_NA; i++) begin
      ocup = ocup + OW'(ativo[i]);
      if (!ativo[i] && !achou) begin
        livre[i] = 1'b1;
        achou    = 1'b1;
      end
    end
  end

  assign ocupacao_out = ocup;
  assign vazio_out    = (ocup == '0);
  assign cheio_out    = (ocup == OW'(NUM_NA));
  assign acerto       = |casa;

  for (genvar i = 0; i < NUM_NA; i++) begin : g_slot
    assign casa[i] = ativo[i] & (endereco[i] == endereco_in);
    assign upd[i]  = op_ins & casa[i] & (distancia_in < distancia[i]);
    assign load[i] = op_ins & ~acerto & livre[i];
    assign clr[i]  = op_clr | (op_pop & (menor_idx == SW'(i)));

    lista_aberta_slot #(
      .ADR_WIDTH(ADR_WIDTH), .DISTANCIA_WIDTH(DISTANCIA_WIDTH), .CRITERIO_WIDTH(CRITERIO_WIDTH)
    ) u_slot (
      .clk(clk), .rst_n(rst_n), .clr(clr[i]), .load(load[i]), .upd(upd[i]),
      .novo_endereco(endereco_in), .novo_distancia(distancia_in),
      .novo_anterior(anterior_in), .novo_criterio(novo_criterio),
      .ativo(ativo[i]), .endereco(endereco[i]), .distancia(distancia[i]),
      .anterior(anterior[i]), .criterio(criterio[i])
    );
  end

  // Ties keep the earlier slot unless DESEMPATE prefers the deeper node.
  always_comb begin
    troca = ativo[cnt] & (~best_vld | (criterio[cnt] < best_crit) |
            ((DESEMPATE != 0) & (criterio[cnt] == best_crit) & (distancia[cnt] > best_dist)));
    nxt_vld  = best_vld | troca;
    nxt_idx  = troca ? cnt : best_idx;
    nxt_crit = troca ? criterio[cnt] : best_crit;
    nxt_dist = troca ? distancia[cnt] : best_dist;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado             <= PRONTO;
      cmd_ready_out      <= 1'b1;
      cnt                <= '0;
      best_vld           <= 1'b0;
      best_idx           <= '0;
      best_crit          <= '0;
      best_dist          <= '0;
      menor_idx          <= '0;
      menor_valido_out   <= 1'b0;
      menor_endereco_out <= '0;
      menor_criterio_out <= '0;
      res_valid_out      <= 1'b0;
      res_endereco_out   <= '0;
      res_distancia_out  <= '0;
      res_anterior_out   <= '0;
      estouro_out        <= 1'b0;
    end else begin
      res_valid_out <= op_pop;
      if (op_pop) begin
        res_endereco_out  <= endereco[menor_idx];
        res_distancia_out <= distancia[menor_idx];
        res_anterior_out  <= anterior[menor_idx];
      end
      if (op_clr)
        estouro_out <= 1'b0;
      else if (op_ins & ~acerto & cheio_out)
        estouro_out <= 1'b1;

      case (estado)
        PRONTO: if (vai_busca) begin
          estado           <= BUSCA;
          cmd_ready_out    <= 1'b0;
          menor_valido_out <= 1'b0;
          cnt              <= '0;
          best_vld         <= 1'b0;
          best_idx         <= '0;
          best_crit        <= '0;
          best_dist        <= '0;
        end
        BUSCA: begin
          best_vld  <= nxt_vld;
          best_idx  <= nxt_idx;
          best_crit <= nxt_crit;
          best_dist <= nxt_dist;
          cnt       <= cnt + SW'(1);
          if (cnt == SW'(NUM_NA-1)) begin
            estado             <= PRONTO;
            cmd_ready_out      <= 1'b1;
            menor_valido_out   <= nxt_vld;
            menor_idx          <= nxt_idx;
            menor_endereco_out <= nxt_vld ? endereco[nxt_idx] : '0;
            menor_criterio_out <= nxt_crit;
          end
        end
        default: estado <= PRONTO;
      endcase
    end
  end
endmodule

// File: tb/tb_lista_aberta.sv
// Two instances (tie-break off/on) driven by the same commands, checked every cycle
// against a per-instance behavioural model of the open list, plus directed literal checks.
module tb_lista_aberta;
  localparam int NA = 4;

  logic clk, rst_n, cmd_valid_in;
  logic [1:0] cmd_op_in;
  logic [4:0] endereco_in, distancia_in, anterior_in;
  logic [3:0] heuristica_in;

  logic       rdy[2], resv[2], mval[2], vaz[2], chei[2], est[2];
  logic [4:0] radr[2], rdist[2], rant[2], madr[2];
  logic [5:0] mcrit[2];
  logic [2:0] ocup[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lista_aberta #(
      .NUM_NA(NA), .ADR_WIDTH(5), .DISTANCIA_WIDTH(5), .CUSTO_WIDTH(4),
      .CRITERIO_WIDTH(6), .DESEMPATE(g)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid_in(cmd_valid_in), .cmd_op_in(cmd_op_in),
      .cmd_ready_out(rdy[g]), .endereco_in(endereco_in), .distancia_in(distancia_in),
      .heuristica_in(heuristica_in), .anterior_in(anterior_in),
      .res_valid_out(resv[g]), .res_endereco_out(radr[g]), .res_distancia_out(rdist[g]),
      .res_anterior_out(rant[g]), .menor_valido_out(mval[g]), .menor_endereco_out(madr[g]),
      .menor_criterio_out(mcrit[g]), .ocupacao_out(ocup[g]), .vazio_out(vaz[g]),
      .cheio_out(chei[g]), .estouro_out(est[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int m, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d at %0t", nm, m, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit e_at[2][NA];
  int e_adr[2][NA], e_dist[2][NA], e_ant[2][NA], e_crit[2][NA];
  int e_busy[2], e_midx[2], e_radr[2], e_rdist[2], e_rant[2], e_madr[2], e_mcrit[2];
  bit e_rdy[2], e_est[2], e_rv[2], e_mv[2];

  function automatic int occ(input int m);
    int n = 0;
    for (int i = 0; i < NA; i++) n += int'(e_at[m][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NA; i++) e_at[m][i] = 0;
      e_busy[m] = 0; e_rdy[m] = 1; e_est[m] = 0; e_rv[m] = 0; e_mv[m] = 0;
      e_midx[m] = 0; e_radr[m] = 0; e_rdist[m] = 0; e_rant[m] = 0;
      e_madr[m] = 0; e_mcrit[m] = 0;
    end
  endtask

  // minimum criterio, then (mode 1) largest distancia among those, then lowest slot
  task automatic latch_min(input int m);
    int minc = 1000, maxd = -1, idx = -1;
    for (int i = 0; i < NA; i++) if (e_at[m][i] && e_crit[m][i] < minc) minc = e_crit[m][i];
    for (int i = 0; i < NA; i++)
      if (e_at[m][i] && e_crit[m][i] == minc && e_dist[m][i] > maxd) maxd = e_dist[m][i];
    for (int i = NA-1; i >= 0; i--)
      if (e_at[m][i] && e_crit[m][i] == minc && (m == 0 || e_dist[m][i] == maxd)) idx = i;
    e_mv[m] = (idx >= 0);
    e_midx[m]  = (idx >= 0) ? idx : 0;
    e_madr[m]  = (idx >= 0) ? e_adr[m][idx] : 0;
    e_mcrit[m] = (idx >= 0) ? minc : 0;
  endtask

  task automatic model_step(input int m);
    int n, hit, fr;
    e_rv[m] = 0;
    if (e_busy[m] > 0) begin
      e_busy[m]--;
      if (e_busy[m] == 0) begin e_rdy[m] = 1; latch_min(m); end
    end else if (cmd_valid_in && cmd_op_in != 2'b00) begin
      n = occ(m);
      if (cmd_op_in == 2'b10 && n == 0) return;
      case (cmd_op_in)
        2'b01: begin
          hit = -1;
          for (int i = 0; i < NA; i++) if (e_at[m][i] && e_adr[m][i] == int'(endereco_in)) hit = i;
          if (hit >= 0) begin
            if (int'(distancia_in) < e_dist[m][hit]) begin
              e_dist[m][hit] = distancia_in; e_ant[m][hit] = anterior_in;
              e_crit[m][hit] = int'(distancia_in) + int'(heuristica_in);
            end
          end else if (n < NA) begin
            fr = -1;
            for (int i = NA-1; i >= 0; i--) if (!e_at[m][i]) fr = i;
            e_at[m][fr] = 1; e_adr[m][fr] = endereco_in; e_dist[m][fr] = distancia_in;
            e_ant[m][fr] = anterior_in; e_crit[m][fr] = int'(distancia_in) + int'(heuristica_in);
          end else e_est[m] = 1;
        end
        2'b10: begin
          e_rv[m] = 1; e_radr[m] = e_adr[m][e_midx[m]];
          e_rdist[m] = e_dist[m][e_midx[m]]; e_rant[m] = e_ant[m][e_midx[m]];
          e_at[m][e_midx[m]] = 0;
        end
        default: begin
          for (int i = 0; i < NA; i++) e_at[m][i] = 0;
          e_est[m] = 0;
        end
      endcase
      e_busy[m] = NA; e_rdy[m] = 0; e_mv[m] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m);
  end

  always @(negedge clk) if (chk_en) begin
    for (int m = 0; m < 2; m++) begin
      chk("ready", m, int'(rdy[m]), int'(e_rdy[m]));
      chk("res_valid", m, int'(resv[m]), int'(e_rv[m]));
      if (e_rv[m]) begin
        chk("res_endereco", m, int'(radr[m]), e_radr[m]);
        chk("res_distancia", m, int'(rdist[m]), e_rdist[m]);
        chk("res_anterior", m, int'(rant[m]), e_rant[m]);
      end
      chk("menor_valido", m, int'(mval[m]), int'(e_mv[m]));
      if (e_mv[m]) begin
        chk("menor_endereco", m, int'(madr[m]), e_madr[m]);
        chk("menor_criterio", m, int'(mcrit[m]), e_mcrit[m]);
      end
      chk("ocupacao", m, int'(ocup[m]), occ(m));
      chk("vazio", m, int'(vaz[m]), int'(occ(m) == 0));
      chk("cheio", m, int'(chei[m]), int'(occ(m) == NA));
      chk("estouro", m, int'(est[m]), int'(e_est[m]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] op, input int a, input int d, input int h, input int an);
    int n = 0;
    cmd_op_in = op; endereco_in = 5'(a); distancia_in = 5'(d);
    heuristica_in = 4'(h); anterior_in = 5'(an); cmd_valid_in = 1'b1;
    while (!rdy[0] && n < 200) begin @(posedge clk); #2; n++; end
    chk("ready_wait", 0, int'(rdy[0]), 1);
    @(posedge clk); #2;
    cmd_valid_in = 1'b0; cmd_op_in = 2'b00;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!rdy[0] && n < 200) begin @(posedge clk); #2; n++; end
    chk("idle_wait", 0, int'(rdy[0]), 1);
  endtask

  task automatic ins(input int a, input int d, input int h, input int an);
    int n;
    send(2'b01, a, d, h, an);
    wait_idle(n);
  endtask

  task automatic clear_all();
    int n;
    send(2'b11, 0, 0, 0, 0);
    wait_idle(n);
  endtask

  task automatic pop_chk(input int a, input int d, input int an);
    int n;
    send(2'b10, 0, 0, 0, 0);
    chk("pop_valid", 0, int'(resv[0]), 1);
    chk("pop_endereco", 0, int'(radr[0]), a);
    chk("pop_distancia", 0, int'(rdist[0]), d);
    chk("pop_anterior", 0, int'(rant[0]), an);
    wait_idle(n);
  endtask

  task automatic reset_vals(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ready"}, m, int'(rdy[m]), 1);
      chk({tag, "_res_valid"}, m, int'(resv[m]), 0);
      chk({tag, "_res_endereco"}, m, int'(radr[m]), 0);
      chk({tag, "_menor_valido"}, m, int'(mval[m]), 0);
      chk({tag, "_menor_endereco"}, m, int'(madr[m]), 0);
      chk({tag, "_menor_criterio"}, m, int'(mcrit[m]), 0);
      chk({tag, "_ocupacao"}, m, int'(ocup[m]), 0);
      chk({tag, "_vazio"}, m, int'(vaz[m]), 1);
      chk({tag, "_cheio"}, m, int'(chei[m]), 0);
      chk({tag, "_estouro"}, m, int'(est[m]), 0);
    end
  endtask

  initial begin
    int n, r;
    rst_n = 1'b0; cmd_valid_in = 1'b0; cmd_op_in = 2'b00;
    endereco_in = '0; distancia_in = '0; heuristica_in = '0; anterior_in = '0;
    @(posedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    reset_vals("reset");

    // first insert: scan length and cached minimum
    send(2'b01, 3, 2, 3, 10);
    wait_idle(n);
    chk("scan_cycles", 0, n, 4);
    chk("menor_endereco_3", 0, int'(madr[0]), 3);
    chk("menor_criterio_5", 0, int'(mcrit[0]), 5);
    chk("ocupacao_1", 0, int'(ocup[0]), 1);
    chk("vazio_0", 0, int'(vaz[0]), 0);

    ins(3, 1, 3, 11);
    chk("decrease_key_crit", 0, int'(mcrit[0]), 4);
    ins(3, 4, 0, 12);
    chk("ignored_crit", 0, int'(mcrit[0]), 4);
    chk("ignored_ocupacao", 0, int'(ocup[0]), 1);

    // tie-break between equal criterio 5
    clear_all();
    ins(5, 1, 4, 0);
    ins(7, 3, 2, 0);
    chk("tie_lowest_slot", 0, int'(madr[0]), 5);
    chk("tie_larger_dist", 1, int'(madr[1]), 7);
    chk("tie_criterio", 1, int'(mcrit[1]), 5);

    // overflow
    clear_all();
    ins(1, 1, 1, 0); ins(2, 2, 1, 0); ins(4, 3, 1, 0); ins(6, 4, 1, 0);
    ins(9, 5, 1, 0);
    chk("full_cheio", 0, int'(chei[0]), 1);
    chk("full_estouro", 0, int'(est[0]), 1);
    chk("full_ocupacao", 0, int'(ocup[0]), 4);
    clear_all();
    chk("clr_estouro", 0, int'(est[0]), 0);
    chk("clr_vazio", 0, int'(vaz[0]), 1);
    chk("clr_menor_valido", 0, int'(mval[0]), 0);

    // pop ordering by criterio 2, 6, 9
    ins(10, 5, 4, 21); ins(11, 1, 1, 22); ins(12, 3, 3, 23);
    pop_chk(11, 1, 22);
    pop_chk(12, 3, 23);
    pop_chk(10, 5, 21);
    send(2'b10, 0, 0, 0, 0);
    chk("empty_pop_valid", 0, int'(resv[0]), 0);
    chk("empty_pop_ready", 0, int'(rdy[0]), 1);

    // randomized traffic, model-checked every cycle
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      r = $urandom_range(0, 99);
      send(r < 50 ? 2'b01 : r < 82 ? 2'b10 : r < 87 ? 2'b11 : 2'b00,
           $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 31));
    end
    wait_idle(n);

    // asynchronous reset two cycles into a scan
    ins(2, 3, 3, 1);
    send(2'b01, 6, 4, 4, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 reset_vals("async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_reset_ready", 0, int'(rdy[0]), 1);
    chk("post_reset_ocupacao", 0, int'(ocup[0]), 0);
    repeat (3) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
